serial_adder: RTL and testbench



---
 rtl/serial_adder_if.sv | 38 +++
 rtl/serial_adder.sv | 127 ++++++++++++
 tb/tb_serial_adder.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_if.sv
// Operand/result bundle for serial_adder. Carries the optional sub
// request when SERIAL_ADDER_SUB_EN is defined.
//
// Handshake: start is a one-cycle request, sampled with a/b (and sub) on
// the rising edge where the adder is IDLE or DONE; start during RUN is
// dropped. busy is high while bits are being added; done pulses for one
// cycle when sum/cout carry the new result, and they hold until the next done.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic [1:0]       dbg_state;

    modport master (
        output start, a, b,
`ifdef SERIAL_ADDER_SUB_EN
        output sub,
`endif
        input  busy, done, sum, cout, dbg_state
    );

    modport slave (
        input  start, a, b,
`ifdef SERIAL_ADDER_SUB_EN
        input  sub,
`endif
        output busy, done, sum, cout, dbg_state
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder, LSB first, one bit per clock, result after WIDTH clocks.
// Defining SERIAL_ADDER_SUB_EN adds a sub request (a-b, cout reports borrow).
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_adder_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             load;
    logic             step;
    logic             last;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             sub_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             sub_in;

    logic             ha1_s;
    logic             ha1_c;
    logic             ha2_s;
    logic             ha2_c;
    logic             fa_s;
    logic             fa_c;

`ifdef SERIAL_ADDER_SUB_EN
    assign sub_in = bus.sub;
`else
    assign sub_in = 1'b0;
`endif

    // Full adder as two half-adder stages: operand bits, then the carry.
    assign ha1_s = a_sh[0] ^ b_sh[0];
    assign ha1_c = a_sh[0] & b_sh[0];
    assign ha2_s = ha1_s ^ carry;
    assign ha2_c = ha1_s & carry;
    assign fa_s  = ha2_s;
    assign fa_c  = ha1_c | ha2_c;

    assign last  = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Sum bits enter a_sh at the MSB as operand bits leave at the LSB, so
    // after WIDTH steps the register holds the full result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sub_q  <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else if (load) begin
            a_sh   <= bus.a;
            b_sh   <= sub_in ? ~bus.b : bus.b;
            carry  <= sub_in;
            cnt    <= '0;
            sub_q  <= sub_in;
        end else if (step) begin
            a_sh   <= {fa_s, a_sh[WIDTH-1:1]};
            b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
            carry  <= fa_c;
            cnt    <= cnt + CNT_W'(1);
            if (last) begin
                sum_q  <= {fa_s, a_sh[WIDTH-1:1]};
                cout_q <= sub_q ? ~fa_c : fa_c;
            end
        end
    end

    assign bus.busy      = (state == RUN);
    assign bus.done      = (state == DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.dbg_state = state;
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=8); the subtract vectors run
// only when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder;
    localparam int WIDTH = 8;

    logic clk;
    logic rst_n;

    serial_adder_if #(.WIDTH(WIDTH)) bus ();

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int               n_tests = 0;
    int               n_fail  = 0;
    logic [WIDTH:0]   exp_q[$];
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub_mode = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- drivers ----------------
    // Called at a falling edge; returns at the next falling edge (1 cycle after E0).
    task automatic launch(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                          input logic [WIDTH:0] exp);
        bus.start = 1'b1;
        bus.a     = av;
        bus.b     = bv;
`ifdef SERIAL_ADDER_SUB_EN
        bus.sub   = sub_mode;
`endif
        exp_q.push_back(exp);
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = WIDTH'($urandom_range(0, 255));
        bus.b     = WIDTH'($urandom_range(0, 255));
`ifdef SERIAL_ADDER_SUB_EN
        bus.sub   = 1'($urandom_range(0, 1));
`endif
    endtask

    // n_start: falling edges already elapsed since the start edge E0.
    task automatic wait_done(input int n_start);
        int             n;
        int             busy_n;
        logic [WIDTH:0] exp;
        n      = n_start;
        busy_n = 0;
        while (!bus.done && n < 40) begin
            if (bus.busy) busy_n++;
            @(negedge clk);
            n++;
        end
        check("latency", n, WIDTH + 1);
        check("busy_cycles", busy_n, WIDTH + 1 - n_start);
        if (bus.done) begin
            check("state_at_done", bus.dbg_state, 2);
            check("busy_at_done", bus.busy, 0);
            check("exp_q_size", exp_q.size(), 1);
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                check("result", {bus.cout, bus.sum}, exp);
            end
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic seen_done;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
`ifdef SERIAL_ADDER_SUB_EN
        bus.sub   = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_sum", bus.sum, 0);
        check("rst_cout", bus.cout, 0);
        check("rst_state", bus.dbg_state, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 0x00 + 0x00
        launch(8'h00, 8'h00, 9'h000);
        check("run_state", bus.dbg_state, 1);
        wait_done(1);

        // 0x5A + 0x33 = 0x8D; done single cycle, sum holds while idle
        @(negedge clk);
        launch(8'h5A, 8'h33, 9'h08D);
        wait_done(1);
        @(negedge clk);
        check("done_pulse_width", bus.done, 0);
        repeat (3) @(negedge clk);
        check("hold_sum", bus.sum, 8'h8D);
        check("hold_cout", bus.cout, 0);
        check("idle_busy", bus.busy, 0);

        // 0xFF + 0x01 overflows; restart in the DONE cycle with 0x80 + 0x80
        launch(8'hFF, 8'h01, 9'h100);
        wait_done(1);
        launch(8'h80, 8'h80, 9'h100);
        check("b2b_done_drop", bus.done, 0);
        check("b2b_busy", bus.busy, 1);
        check("b2b_hold_sum", bus.sum, 8'h00);
        check("b2b_hold_cout", bus.cout, 1);
        wait_done(1);

        // A start during RUN must not re-sample operands
        @(negedge clk);
        launch(8'h10, 8'h01, 9'h011);
        repeat (2) @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'hFF;
        bus.b     = 8'hFF;
        @(negedge clk);
        bus.start = 1'b0;
        check("run_sum_stable", bus.sum, 8'h00);
        wait_done(4);

        // 0x9C + 0x87 = 0x123
        @(negedge clk);
        launch(8'h9C, 8'h87, 9'h123);
        wait_done(1);

        // Reset in the middle of a run discards it
        @(negedge clk);
        launch(8'hAA, 8'h55, 9'h0FF);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_done", bus.done, 0);
        check("mid_rst_sum", bus.sum, 0);
        check("mid_rst_cout", bus.cout, 0);
        check("mid_rst_state", bus.dbg_state, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        repeat (12) begin
            @(negedge clk);
            seen_done = seen_done | bus.done;
        end
        check("no_done_after_rst", seen_done, 0);
        launch(8'hAA, 8'h55, 9'h0FF);
        wait_done(1);

`ifdef SERIAL_ADDER_SUB_EN
        // Subtraction: cout is borrow (1 when a < b)
        @(negedge clk);
        sub_mode = 1'b1;
        launch(8'h05, 8'h07, 9'h1FE);
        wait_done(1);
        @(negedge clk);
        launch(8'h07, 8'h05, 9'h002);
        wait_done(1);
        @(negedge clk);
        sub_mode = 1'b0;
        launch(8'h07, 8'h05, 9'h00C);
        wait_done(1);
`endif

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
